fft_reorder: RTL and testbench
==============================

# fft_reorder

Output reorder buffer at the tail of the 16-point FFT pipeline. It receives the pipeline's complex output stream, which arrives in bit-reversed index order, and re-emits each frame in natural order on a valid/ready interface. Two ping-pong frame banks let one frame be written while the previous one is read out. It drives the pipeline's `stall` input when both banks are occupied.

## Interface
- `DATA_WIDTH`, 12, width of each real/imag component (signed).
- `N`, 16, frame length; must be a power of 2 and ≥ 2. `LOG2N = $clog2(N)` is a localparam.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data_r` in DATA_WIDTH: signed real part from the pipeline.
- `in_data_i` in DATA_WIDTH: signed imaginary part from the pipeline.
- `valid_in` in 1: input sample valid.
- `stall_out` out 1: freeze request to the upstream pipeline `stall`.
- `out_data_r` out DATA_WIDTH: signed real part, natural order.
- `out_data_i` out DATA_WIDTH: signed imaginary part, natural order.
- `valid_out` out 1: output sample valid.
- `last_out` out 1: high with the final sample (index N-1) of a frame.
- `ready_in` in 1: downstream can accept a sample.

## Operation
- **Storage**
  - Two banks, each N × 2·DATA_WIDTH. Memory contents are not reset.
  - Per-bank flag `full[b]`. Write-bank pointer `wb` and read-bank pointer `rb`, each 1 bit.
  - Counters `wcnt` and `rcnt`, each LOG2N bits.
- **Accept rule**
  - A sample is accepted when `valid_in && !stall_out`.
  - `valid_in` while `stall_out=1` is ignored. The pipeline holds the sample and re-presents it.
- **Write**
  - On accept, store to `bank[wb][bitrev(wcnt)]`, where `bitrev` reverses the LOG2N bits. Then `wcnt++`.
  - When `wcnt==N-1` is accepted: set `full[wb]`, toggle `wb`, and wrap `wcnt` to 0.
- **Stall**
  - `stall_out = full[wb]`, taken directly from registers with no combinational path from any input.
- **Read / output register**
  - The output register advances when `!valid_out || ready_in`.
  - On advance with `full[rb]=1`: load `bank[rb][rcnt]` into the output, set `valid_out=1`, set `last_out=(rcnt==N-1)`, then `rcnt++`.
  - When `rcnt==N-1` is loaded: clear `full[rb]`, toggle `rb`, and wrap `rcnt` to 0.
  - On advance with `full[rb]=0`: set `valid_out=0` and `last_out=0`. Data may hold its old value.
  - While `valid_out && !ready_in`: all outputs hold stable.
- **Gaps**
  - `valid_in` gaps mid-frame are allowed; `wcnt` holds.
  - `ready_in` gaps mid-frame are allowed; `rcnt` holds.
- **Simultaneous events**
  - Setting `full[wb]` and clearing `full[rb]` in the same cycle both take effect, since they are different banks.
  - A bank freed on edge t becomes writable from cycle t+1 (the `stall_out` drop is seen after edge t).
- **Reset (async, any time, including mid-frame)**
  - Counters, pointers and full flags go to 0.
  - Outputs: `valid_out=0`, `last_out=0`, `out_data_r=0`, `out_data_i=0`, `stall_out=0`.
  - Any partial frame and any unread frame are discarded.

## Timing
- Latency: the last sample of a frame is accepted at edge t. `full` is set at t, and the first natural-order sample is presented after edge t+1 when `ready_in=1`.
- Throughput: with `valid_in` continuous and `ready_in=1`, the block accepts one sample per cycle and outputs one sample per cycle indefinitely. `stall_out` never asserts.
- `stall_out` asserts only when both banks are full. It deasserts the cycle after the edge that reads out sample N-1 of the read bank.
- Backpressure: output data, `valid_out` and `last_out` are stable from assertion until the cycle with `ready_in=1`.

## Test plan
- **Bit-reversal, N=16**
  - Stimulus: feed k=0..15 continuously with `in_data_r=k`, `in_data_i=-k`, `ready_in=1`.
  - Required: outputs `out_data_r` = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with matching negated `out_data_i`. First `valid_out` one cycle after the edge accepting k=15. `last_out` high only on the 16th output.
- **Streaming**
  - Stimulus: 4 back-to-back frames with `ready_in=1`.
  - Required: `stall_out` stays 0 throughout; 64 outputs with no `valid_out` bubble after the first.
- **Backpressure / stall**
  - Stimulus: hold `ready_in=0` and feed 3 frames.
  - Required: `stall_out` rises right after frame 1 completes. Third-frame samples are not consumed. After releasing `ready_in`, all 48 samples come out in order, with no loss or duplication.
- **Output hold**
  - Stimulus: toggle `ready_in` pseudo-randomly mid-frame.
  - Required: data and `last_out` stay stable while `valid_out && !ready_in`; the sequence is unchanged.
- **Input gaps**
  - Stimulus: insert random `valid_in=0` cycles inside frames.
  - Required: output ordering is identical to the gap-free case.
- **Reset mid-operation**
  - Stimulus: assert `rst_n=0` after 7 samples of frame 0, then send a fresh frame.
  - Required: all outputs are 0 during reset, and only the fresh frame appears, correctly reordered.

Source files
------------

// File: rtl/fft_reorder.sv
// fft_reorder: bit-reversed to natural-order frame reorder buffer for the FFT tail.
// Two ping-pong banks: one is written in bit-reversed order while the other is read out
// in natural order on a valid/ready interface.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   in_data_r/in_data_i     - signed complex sample from the pipeline
//   valid_in                - input sample valid (accepted when !stall_out)
//   stall_out               - freeze request to upstream; high while the write bank is full
//   out_data_r/out_data_i   - signed complex sample, natural order
//   valid_out, last_out     - output valid; last_out marks index N-1 of a frame
//   ready_in                - downstream accepts the output sample
module fft_reorder #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned N          = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] in_data_r,
  input  logic signed [DATA_WIDTH-1:0] in_data_i,
  input  logic                         valid_in,
  output logic                         stall_out,
  output logic signed [DATA_WIDTH-1:0] out_data_r,
  output logic signed [DATA_WIDTH-1:0] out_data_i,
  output logic                         valid_out,
  output logic                         last_out,
  input  logic                         ready_in
);

  localparam int unsigned LOG2N = $clog2(N);
  localparam int unsigned W     = 2 * DATA_WIDTH;
  localparam logic [LOG2N-1:0] LastIdx = LOG2N'(N - 1);

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

  logic [W-1:0] mem_q [0:1][0:N-1];

  logic [1:0]       full_q, full_d;
  logic             wb_q, wb_d, rb_q, rb_d;
  logic [LOG2N-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic signed [DATA_WIDTH-1:0] out_r_q, out_r_d, out_i_q, out_i_d;
  logic             valid_q, valid_d, last_q, last_d;

  logic             accept, advance;
  logic [LOG2N-1:0] wr_addr;
  logic [W-1:0]     wr_word, rd_word;

  assign accept  = valid_in && !full_q[wb_q];
  assign advance = !valid_q || ready_in;
  assign wr_addr = bitrev(wcnt_q);
  assign wr_word = {in_data_r, in_data_i};
  assign rd_word = mem_q[rb_q][rcnt_q];

  always_comb begin
    full_d  = full_q;
    wb_d    = wb_q;
    rb_d    = rb_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    out_r_d = out_r_q;
    out_i_d = out_i_q;
    valid_d = valid_q;
    last_d  = last_q;

    if (accept) begin
      wcnt_d = wcnt_q + LOG2N'(1);
      if (wcnt_q == LastIdx) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        wcnt_d       = '0;
      end
    end

    // Write and read banks always differ when both events fire, so the two
    // full_d updates never collide.
    if (advance) begin
      if (full_q[rb_q]) begin
        out_r_d = rd_word[W-1:DATA_WIDTH];
        out_i_d = rd_word[DATA_WIDTH-1:0];
        valid_d = 1'b1;
        last_d  = (rcnt_q == LastIdx);
        rcnt_d  = rcnt_q + LOG2N'(1);
        if (rcnt_q == LastIdx) begin
          full_d[rb_q] = 1'b0;
          rb_d         = ~rb_q;
          rcnt_d       = '0;
        end
      end else begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= '0;
      wb_q    <= 1'b0;
      rb_q    <= 1'b0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      out_r_q <= '0;
      out_i_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      full_q  <= full_d;
      wb_q    <= wb_d;
      rb_q    <= rb_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      out_r_q <= out_r_d;
      out_i_q <= out_i_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // Frame storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wb_q][wr_addr] <= wr_word;
    end
  end

  assign stall_out  = full_q[wb_q];
  assign out_data_r = out_r_q;
  assign out_data_i = out_i_q;
  assign valid_out  = valid_q;
  assign last_out   = last_q;

endmodule

// File: tb/tb_fft_reorder.sv
// Scoreboard bench for fft_reorder: the driver pushes the expected natural-order frame
// when a frame has been fully accepted; a monitor pops and compares on every transfer.
module tb_fft_reorder;

  localparam int DW = 12;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic signed [DW-1:0] in_data_r, in_data_i;
  logic                 valid_in;
  logic                 stall_out;
  logic signed [DW-1:0] out_data_r, out_data_i;
  logic                 valid_out, last_out;
  logic                 ready_in;

  fft_reorder #(.DATA_WIDTH(DW), .N(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data_r  (in_data_r),
    .in_data_i  (in_data_i),
    .valid_in   (valid_in),
    .stall_out  (stall_out),
    .out_data_r (out_data_r),
    .out_data_i (out_data_i),
    .valid_out  (valid_out),
    .last_out   (last_out),
    .ready_in   (ready_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int i;
    int last;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   acc_cnt = 0;
  int   ready_mode = 1;  // 0: hold low, 1: hold high, 2: pseudo-random
  // Hand-computed bit-reversed index of each natural-order output position.
  int   order[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  bit   stream_mode = 1'b0;
  int   stream_seen = 0;
  int   stream_bubble = 0;
  int   stream_stall = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Ready driver, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       ready_in = 1'b0;
      1:       ready_in = 1'b1;
      default: ready_in = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: sample on the falling edge, away from the active edge.
  bit hold_pend = 1'b0;
  int hold_r, hold_i, hold_l;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", int'(valid_out), 1);
        chk("hold_data_r", int'(out_data_r), hold_r);
        chk("hold_data_i", int'(out_data_i), hold_i);
        chk("hold_last", int'(last_out), hold_l);
      end
      if (valid_out && ready_in) begin
        if (q.size() == 0) begin
          chk("unexpected_output", int'(out_data_r), -9999);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data_r", int'(out_data_r), e.r);
          chk("out_data_i", int'(out_data_i), e.i);
          chk("last_out", int'(last_out), e.last);
        end
      end
      hold_pend = valid_out && !ready_in;
      hold_r = int'(out_data_r);
      hold_i = int'(out_data_i);
      hold_l = int'(last_out);
      if (stream_mode) begin
        if (stall_out) stream_stall++;
        if (valid_out) stream_seen++;
        else if (stream_seen > 0 && stream_seen < 64) stream_bubble++;
      end
    end
  end

  // Present one sample until accepted; entered and left at posedge + #1.
  task automatic send_sample(input int v);
    bit st;
    int t;
    t = 0;
    valid_in  = 1'b1;
    in_data_r = DW'(v);
    in_data_i = DW'(-v);
    do begin
      @(negedge clk);
      st = stall_out;
      @(posedge clk);
      #1;
      t++;
      if (t > 5000) begin
        $display("FAIL send_timeout: got %0d expected accept", t);
        $fatal(1, "input never accepted");
      end
    end while (st);
    acc_cnt++;
  endtask

  task automatic send_frame(input int base, input bit gaps);
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        valid_in = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_sample(base + k);
    end
    valid_in = 1'b0;
    for (int j = 0; j < 16; j++) begin
      e.r = base + order[j];
      e.i = -(base + order[j]);
      e.last = (j == 15) ? 1 : 0;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || valid_out) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_in_time", int'(t < 3000), 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    in_data_r = '0;
    in_data_i = '0;
    ready_in  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_last", int'(last_out), 0);
    chk("rst_stall", int'(stall_out), 0);
    chk("rst_data_r", int'(out_data_r), 0);
    chk("rst_data_i", int'(out_data_i), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Bit reversal and first-output latency.
    send_frame(0, 1'b0);
    @(negedge clk);
    chk("latency_not_yet", int'(valid_out), 0);
    @(negedge clk);
    chk("latency_first", int'(valid_out), 1);
    drain();

    // Streaming: four back-to-back frames.
    stream_mode = 1'b1;
    for (int f = 0; f < 4; f++) send_frame(100 + 16 * f, 1'b0);
    drain();
    stream_mode = 1'b0;
    chk("stream_stall", stream_stall, 0);
    chk("stream_bubble", stream_bubble, 0);
    chk("stream_count", stream_seen, 64);

    // Backpressure: three frames with ready held low.
    ready_mode = 0;
    @(posedge clk);
    #1;
    acc_cnt = 0;
    fork
      begin
        send_frame(300, 1'b0);
        chk("bp_stall_after_f0", int'(stall_out), 0);
        send_frame(400, 1'b0);
        chk("bp_stall_after_f1", int'(stall_out), 1);
        send_frame(500, 1'b0);
      end
      begin
        int t;
        t = 0;
        while (acc_cnt < 32 && t < 2000) begin
          @(posedge clk);
          t++;
        end
        repeat (20) @(posedge clk);
        #1;
        chk("bp_stall_held", int'(stall_out), 1);
        chk("bp_no_third_consumed", acc_cnt, 32);
        ready_mode = 1;
      end
    join
    drain();

    // Output hold under random ready.
    ready_mode = 2;
    send_frame(600, 1'b0);
    send_frame(700, 1'b0);
    drain();

    // Input gaps.
    ready_mode = 1;
    send_frame(800, 1'b1);
    send_frame(900, 1'b1);
    drain();

    // Reset after 7 samples of a frame.
    for (int k = 0; k < 7; k++) send_sample(1000 + k);
    valid_in = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", int'(valid_out), 0);
    chk("mid_rst_last", int'(last_out), 0);
    chk("mid_rst_stall", int'(stall_out), 0);
    chk("mid_rst_data_r", int'(out_data_r), 0);
    chk("mid_rst_data_i", int'(out_data_i), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(1100, 1'b0);
    drain();
    repeat (5) @(posedge clk);
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
